ps2_packet_rx: RTL
==================

# ps2_packet_rx

Parametrised PS/2 receiver for the mouse/keyboard front end. Runs entirely on `qzt_clk`; no divided clock domains. It synchronises and deglitches `PS2C`/`PS2D`, decodes 11-bit frames, and checks start, parity and stop bits. It assembles `PKT_BYTES` consecutive bytes into one packet delivered with a single-cycle valid pulse, and reports frame, bit and inter-byte timeout errors with a code.

## Interface
- `TICK_DIV`, 50: `qzt_clk` cycles per 1 µs timebase tick (50 for 50 MHz).
- `PKT_BYTES`, 3: bytes per packet (1..4).
- `FILTER_LEN`, 8: consecutive identical samples needed before a filtered line changes (2..31).
- `FRAME_TO_US`, 2000: maximum µs from start edge to stop-bit edge.
- `BYTE_TO_US`, 1000: maximum µs from a byte's stop-bit edge to the next start edge inside a packet.
- `GAP_US`, 100: µs both lines must be continuously high before returning to idle after an error.

Ports:
- `qzt_clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `enable`, input, 1: receiver enable; low aborts and holds IDLE.
- `PS2C`, input, 1: raw PS/2 clock (asynchronous).
- `PS2D`, input, 1: raw PS/2 data (asynchronous).
- `busy`, output, 1: high whenever state ≠ IDLE.
- `pkt_data`, output, 8*PKT_BYTES: last good packet; byte 0 in bits [7:0].
- `pkt_valid`, output, 1: one-cycle pulse, `pkt_data` newly updated.
- `err`, output, 1: one-cycle pulse on error detection.
- `errcode`, output, 8: code of the most recent error; held until the next error.

## Operation
- Input path: 2-FF synchroniser per line, then a saturating filter. Filtered level flips after `FILTER_LEN` equal consecutive synced samples. Reset value of filtered lines is 1.
- Edge detect: falling edge of filtered clock = registered 1 and current 0.
- Timebase: free-running divider, 1-cycle `tick` every `TICK_DIV` cycles. All timeouts count ticks, with ±1 µs resolution.
- States:
  - IDLE → FRAME on falling edge with filtered data = 0. Clear bit counter, start frame timer.
  - IDLE, falling edge with data = 1 → ERRWAIT, code 2.
  - FRAME: each falling edge shifts filtered data into shift register; bits 1..8 are data LSB first, bit 9 is parity, bit 10 is stop.
  - FRAME, on bit 10 → CHECK.
- CHECK (one cycle):
  - Parity: XOR of 8 data bits and parity bit must be 1 (odd); else code 3.
  - Stop bit must be 1; else code 4.
  - Good byte: written into slot `byte_idx`.
  - If `byte_idx` = `PKT_BYTES`-1: load `pkt_data`, pulse `pkt_valid`, clear `byte_idx`, → IDLE.
  - Otherwise: increment `byte_idx`, → WAITBYTE.
- WAITBYTE:
  - Start edge (data 0) → FRAME.
  - Data 1 on edge → ERRWAIT, code 2.
  - `BYTE_TO_US` elapses → ERRWAIT, code 5.
- FRAME: `FRAME_TO_US` elapses before bit 10 → ERRWAIT, code 1.
- Any error:
  - Discard partial packet, clear `byte_idx`.
  - `pkt_data` is unchanged.
  - `err` pulse, `errcode` loaded.
- ERRWAIT: gap counter resets whenever either filtered line is low. Once it reaches `GAP_US` → IDLE.
- `enable` low in any state: next cycle state = IDLE, `byte_idx` = 0, partial discarded, no `err`, no `pkt_valid`. Edges are ignored while low.
- `rst` has priority over everything.
- Simultaneous events:
  - A timeout and a clock edge in the same cycle: timeout wins.
  - An error and `pkt_valid` can never coincide.

## Timing
- Reset values: `busy` = 0, `pkt_data` = 0, `pkt_valid` = 0, `err` = 0, `errcode` = 0. State IDLE, `byte_idx` 0, tick divider 0.
- Input latency: raw pin change to filtered change = 2 + `FILTER_LEN` cycles.
- `pkt_valid`/`err` for a parity or stop error: asserted 2 cycles after the filtered falling edge of bit 10. That is one cycle into FRAME→CHECK, then the registered outputs.
- `pkt_data` is stable from `pkt_valid` until the next `pkt_valid`.
- `busy` rises the cycle after the start edge and falls the cycle after returning to IDLE.
- Timeout `err`: the cycle after the tick count reaches its limit.

## Test plan
- Common bench setting: `TICK_DIV`=5, `PKT_BYTES`=3, `FILTER_LEN`=4; PS/2 clock period 80 µs.
- Good packet: frames 0x08, 0x05, 0xFB with correct parity → one `pkt_valid`, `pkt_data`=0xFB0508, `err` never high.
- Parity error: byte 2 sent with flipped parity → `err` pulse, `errcode`=3, no `pkt_valid`, `pkt_data` keeps the previous value.
- Inter-byte timeout: two bytes, then lines idle for 1200 µs → `errcode`=5 at ~1000 µs after the second stop edge. The next full 3-byte packet is then received correctly.
- Glitch rejection: 2-cycle low pulses on `PS2C` during IDLE → no state change, `busy` stays 0.
- Abort: `enable` dropped mid-frame of byte 1, restored, full packet sent → exactly one `pkt_valid` with the new data, no `err`.
- Frame timeout and reset: clock stops after bit 5 → `errcode`=1 at 2000 µs. Asserting `rst` during ERRWAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/ps2_packet_rx.sv
// rtl/ps2_packet_rx.sv - PS/2 packet receiver: deglitch, 11-bit framing checks, packet assembly, timeouts
module ps2_packet_rx #(
  parameter int TICK_DIV    = 50,
  parameter int PKT_BYTES   = 3,
  parameter int FILTER_LEN  = 8,
  parameter int FRAME_TO_US = 2000,
  parameter int BYTE_TO_US  = 1000,
  parameter int GAP_US      = 100
) (
  input  logic                   qzt_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   PS2C,
  input  logic                   PS2D,
  output logic                   busy,
  output logic [8*PKT_BYTES-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   err,
  output logic [7:0]             errcode
);

  localparam int PW     = 8 * PKT_BYTES;
  localparam int FW     = $clog2(FILTER_LEN + 1);
  localparam int DW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int TO_A   = (FRAME_TO_US > BYTE_TO_US) ? FRAME_TO_US : BYTE_TO_US;
  localparam int TO_MAX = (TO_A > GAP_US) ? TO_A : GAP_US;
  localparam int TW     = $clog2(TO_MAX + 1);

  localparam logic [7:0] E_FRAME_TO = 8'd1;
  localparam logic [7:0] E_START    = 8'd2;
  localparam logic [7:0] E_PARITY   = 8'd3;
  localparam logic [7:0] E_STOP     = 8'd4;
  localparam logic [7:0] E_BYTE_TO  = 8'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME,
    S_CHECK,
    S_WAITBYTE,
    S_ERRWAIT
  } state_t;

  state_t state_q, state_d;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  logic               clk_prev_q, clk_prev_d;
  logic [DW-1:0]      div_q, div_d;

  logic [TW-1:0]      tmr_q, tmr_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [9:0]         sh_q, sh_d;
  logic [IW-1:0]      byte_idx_q, byte_idx_d;
  logic [PW-1:0]      buf_q, buf_d, buf_next;
  logic [PW-1:0]      pkt_data_q, pkt_data_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               err_q, err_d;
  logic [7:0]         errcode_q, errcode_d;

  logic               tick, fall, dat_f;
  logic               frame_to, byte_to, gap_done;
  logic               parity_ok, stop_ok, last_byte;
  logic               err_hit;
  logic [7:0]         err_code_c;

  assign tick      = (div_q == DW'(TICK_DIV - 1));
  assign fall      = clk_prev_q & ~filt_q[0];
  assign dat_f     = filt_q[1];
  assign frame_to  = (tmr_q >= TW'(FRAME_TO_US));
  assign byte_to   = (tmr_q >= TW'(BYTE_TO_US));
  assign gap_done  = (tmr_q >= TW'(GAP_US));
  assign parity_ok = ^sh_q[8:0];
  assign stop_ok   = sh_q[9];
  assign last_byte = (byte_idx_q == IW'(PKT_BYTES - 1));

  // A filtered line only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sync1_d    = {PS2D, PS2C};
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
    clk_prev_d = filt_q[0];
    div_d      = tick ? '0 : div_q + DW'(1);
  end

  always_comb begin
    buf_next = buf_q;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (byte_idx_q == IW'(i)) buf_next[8*i +: 8] = sh_q[7:0];
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (fall) state_d = dat_f ? S_ERRWAIT : S_FRAME;
        S_FRAME: begin
          if (frame_to)                      state_d = S_ERRWAIT;
          else if (fall && bit_cnt_q == 4'd9) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (!parity_ok || !stop_ok) state_d = S_ERRWAIT;
          else if (last_byte)         state_d = S_IDLE;
          else                        state_d = S_WAITBYTE;
        end
        S_WAITBYTE: begin
          if (byte_to)   state_d = S_ERRWAIT;
          else if (fall) state_d = dat_f ? S_ERRWAIT : S_FRAME;
        end
        S_ERRWAIT:  if (gap_done) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Timeouts are tested before edges so a coinciding edge never masks them.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    tmr_d       = tick ? tmr_q + TW'(1) : tmr_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = 1'b0;
    err_d       = 1'b0;
    errcode_d   = errcode_q;
    err_hit     = 1'b0;
    err_code_c  = '0;
    if (!enable) begin
      byte_idx_d = '0;
      tmr_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmr_d     = '0;
          bit_cnt_d = '0;
          if (fall && dat_f) begin
            err_hit    = 1'b1;
            err_code_c = E_START;
          end
        end
        S_FRAME: begin
          if (frame_to) begin
            err_hit    = 1'b1;
            err_code_c = E_FRAME_TO;
          end else if (fall) begin
            sh_d      = {dat_f, sh_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_CHECK: begin
          tmr_d = '0;
          if (!parity_ok) begin
            err_hit    = 1'b1;
            err_code_c = E_PARITY;
          end else if (!stop_ok) begin
            err_hit    = 1'b1;
            err_code_c = E_STOP;
          end else begin
            buf_d = buf_next;
            if (last_byte) begin
              pkt_data_d  = buf_next;
              pkt_valid_d = 1'b1;
              byte_idx_d  = '0;
            end else begin
              byte_idx_d = byte_idx_q + IW'(1);
            end
          end
        end
        S_WAITBYTE: begin
          if (byte_to) begin
            err_hit    = 1'b1;
            err_code_c = E_BYTE_TO;
          end else if (fall) begin
            tmr_d     = '0;
            bit_cnt_d = '0;
            if (dat_f) begin
              err_hit    = 1'b1;
              err_code_c = E_START;
            end
          end
        end
        S_ERRWAIT: if (!filt_q[0] || !filt_q[1]) tmr_d = '0;
        default: ;
      endcase
      if (err_hit) begin
        err_d      = 1'b1;
        errcode_d  = err_code_c;
        byte_idx_d = '0;
        tmr_d      = '0;
      end
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      fcnt_q      <= '0;
      clk_prev_q  <= 1'b1;
      div_q       <= '0;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      errcode_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      clk_prev_q  <= clk_prev_d;
      div_q       <= div_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      err_q       <= err_d;
      errcode_q   <= errcode_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign err       = err_q;
  assign errcode   = errcode_q;

endmodule
